// File: rtl/bayer_frame_ctrl.sv
// Frame/line sequencer for the Bayer capture path: gates camera syncs, counts pixels/lines, emits CFA phase, events and geometry errors.
// Latency: every output is registered, one pclk after the sampled camera inputs.
// Backpressure: none; the camera stream cannot be stalled, so the block only observes and flags.
module bayer_frame_ctrl #(
  parameter int H_ACT = 1280,
  parameter int V_ACT = 720,
  parameter int XW    = 12,
  parameter int YW    = 11
) (
  input  logic          pclk,
  input  logic          rst,
  input  logic          cfg_enable,
  input  logic [1:0]    cfg_pattern,
  input  logic          err_clr,
  input  logic          in_href,
  input  logic          in_vsync,
  output logic          out_href,
  output logic          out_vsync,
  output logic [1:0]    pix_phase,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          frame_start,
  output logic          line_end,
  output logic          frame_done,
  output logic          err_line_len,
  output logic          err_frame_len,
  output logic          busy
);

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    IN_VS   = 2'd1,
    ACTIVE  = 2'd2
  } state_t;

  localparam logic [XW-1:0] LP_H_ACT = XW'(H_ACT);
  localparam logic [YW-1:0] LP_V_ACT = YW'(V_ACT);

  state_t        r_state;
  state_t        w_state_nxt;
  logic          r_vs_d;
  logic [XW-1:0] r_x_cnt;
  logic [YW-1:0] r_y_cnt;
  logic [1:0]    r_pattern;

  logic          w_active;
  logic          w_pixel;
  logic          w_href_fall;
  logic          w_vs_rise;
  logic          w_vs_fall;
  logic [XW-1:0] w_x_inc;
  logic [YW-1:0] w_y_inc;
  logic [YW-1:0] w_y_done;
  logic          w_line_bad;
  logic          w_frame_bad;

  // Event decode from the current camera inputs and their registered history.
  // The href fall uses the gated out_href so href seen outside ACTIVE never yields a line event.
  always_comb begin
    w_active    = (r_state == ACTIVE);
    w_pixel     = w_active && in_href;
    w_href_fall = w_active && out_href && !in_href;
    w_vs_rise   = w_active && in_vsync && !r_vs_d;
    w_vs_fall   = r_vs_d && !in_vsync;
    w_x_inc     = (r_x_cnt == {XW{1'b1}}) ? r_x_cnt : r_x_cnt + 1'b1;
    w_y_inc     = (r_y_cnt == {YW{1'b1}}) ? r_y_cnt : r_y_cnt + 1'b1;
    // A line closing in the same cycle as the frame still counts toward this frame.
    w_y_done    = w_href_fall ? w_y_inc : r_y_cnt;
    w_line_bad  = w_href_fall && (r_x_cnt != LP_H_ACT);
    w_frame_bad = w_vs_rise && (w_y_done != LP_V_ACT);
  end

  // Next-state logic: capture arms on vsync, starts on its falling edge, ends on the next rising edge.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      WAIT_VS: if (cfg_enable && in_vsync) w_state_nxt = IN_VS;
      IN_VS:   if (w_vs_fall) w_state_nxt = ACTIVE;
      ACTIVE:  if (w_vs_rise) w_state_nxt = cfg_enable ? IN_VS : WAIT_VS;
      default: w_state_nxt = WAIT_VS;
    endcase
  end

  // State register.
  always_ff @(posedge pclk) begin
    if (rst) r_state <= WAIT_VS;
    else     r_state <= w_state_nxt;
  end

  // Pixel/line counters and the per-frame CFA shadow, reloaded when a frame begins.
  always_ff @(posedge pclk) begin
    if (rst) begin
      r_vs_d    <= 1'b0;
      r_x_cnt   <= '0;
      r_y_cnt   <= '0;
      r_pattern <= 2'b00;
    end else begin
      r_vs_d <= in_vsync;
      if (r_state == IN_VS && w_vs_fall) begin
        r_x_cnt   <= '0;
        r_y_cnt   <= '0;
        r_pattern <= cfg_pattern;
      end else if (w_pixel) begin
        r_x_cnt <= w_x_inc;
      end else if (w_href_fall) begin
        r_x_cnt <= '0;
        r_y_cnt <= w_y_inc;
      end
    end
  end

  // Registered stream outputs; coordinates and phase describe the pixel sampled this cycle.
  always_ff @(posedge pclk) begin
    if (rst) begin
      out_href    <= 1'b0;
      out_vsync   <= 1'b0;
      pix_phase   <= 2'b00;
      pix_x       <= '0;
      pix_y       <= '0;
      frame_start <= 1'b0;
      line_end    <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      out_href    <= w_pixel;
      out_vsync   <= in_vsync;
      pix_phase   <= w_pixel ? (r_pattern ^ {r_y_cnt[0], r_x_cnt[0]}) : 2'b00;
      pix_x       <= w_pixel ? r_x_cnt : '0;
      pix_y       <= r_y_cnt;
      frame_start <= w_pixel && (r_x_cnt == '0) && (r_y_cnt == '0);
      line_end    <= w_href_fall;
      frame_done  <= w_vs_rise;
    end
  end

  // Sticky geometry errors; a new error event takes priority over a clear in the same cycle.
  always_ff @(posedge pclk) begin
    if (rst) begin
      err_line_len  <= 1'b0;
      err_frame_len <= 1'b0;
    end else begin
      if (w_line_bad)   err_line_len <= 1'b1;
      else if (err_clr) err_line_len <= 1'b0;
      if (w_frame_bad)  err_frame_len <= 1'b1;
      else if (err_clr) err_frame_len <= 1'b0;
    end
  end

  assign busy = (r_state != WAIT_VS);

endmodule

// File: tb/tb_bayer_frame_ctrl.sv
// Directed bench for bayer_frame_ctrl with an 8x4 frame geometry.
// Inputs change 1 ns after each rising edge; outputs are read at the same point.
// Each scenario task checks its own expectations inline.
module tb_bayer_frame_ctrl;

  logic        pclk;
  logic        rst;
  logic        cfg_enable;
  logic [1:0]  cfg_pattern;
  logic        err_clr;
  logic        in_href;
  logic        in_vsync;
  logic        out_href;
  logic        out_vsync;
  logic [1:0]  pix_phase;
  logic [11:0] pix_x;
  logic [10:0] pix_y;
  logic        frame_start;
  logic        line_end;
  logic        frame_done;
  logic        err_line_len;
  logic        err_frame_len;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int n_fs, n_le, n_fd;

  logic [1:0]  ph_log [0:7][0:15];
  logic [11:0] x_log  [0:7][0:15];
  logic [10:0] y_log  [0:7];
  logic        le_log [0:7];
  logic        ele_log[0:7];

  bayer_frame_ctrl #(.H_ACT(8), .V_ACT(4), .XW(12), .YW(11)) dut (
    .pclk(pclk), .rst(rst), .cfg_enable(cfg_enable), .cfg_pattern(cfg_pattern),
    .err_clr(err_clr), .in_href(in_href), .in_vsync(in_vsync),
    .out_href(out_href), .out_vsync(out_vsync), .pix_phase(pix_phase),
    .pix_x(pix_x), .pix_y(pix_y), .frame_start(frame_start), .line_end(line_end),
    .frame_done(frame_done), .err_line_len(err_line_len),
    .err_frame_len(err_frame_len), .busy(busy)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // One clock with the given camera inputs; outputs reflect them on return.
  task automatic cyc(input logic h, input logic v);
    in_href  = h;
    in_vsync = v;
    @(posedge pclk);
    #1;
    if (frame_start) n_fs++;
    if (line_end)    n_le++;
    if (frame_done)  n_fd++;
  endtask

  // Vsync pulse, nlines lines (8 pixels, or 7 on short_line), then the closing vsync edge.
  task automatic run_frame(input int nlines, input int short_line, input int chg_line,
                           input logic [1:0] chg_pat, input int clr_line, input int drop_line);
    int len;
    n_fs = 0; n_le = 0; n_fd = 0;
    cyc(0, 1); cyc(0, 1); cyc(0, 0);
    for (int l = 0; l < nlines; l++) begin
      if (l == chg_line)  cfg_pattern = chg_pat;
      if (l == drop_line) cfg_enable  = 1'b0;
      len = (l == short_line) ? 7 : 8;
      for (int p = 0; p < len; p++) begin
        cyc(1, 0);
        ph_log[l][p] = pix_phase;
        x_log[l][p]  = pix_x;
        if (p == 0) y_log[l] = pix_y;
      end
      if (l == clr_line) err_clr = 1'b1;
      cyc(0, 0);
      err_clr    = 1'b0;
      le_log[l]  = line_end;
      ele_log[l] = err_line_len;
      cyc(0, 0);
    end
    cyc(0, 1);
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_enable = 1'b0; cfg_pattern = 2'b00; err_clr = 1'b0;
    cyc(0, 1);
    cyc(1, 1);
    checks++;
    if ({out_href, out_vsync, frame_start, line_end, frame_done} !== 5'b0) begin
      errors++; $display("FAIL reset_pulses: got %b required 00000", {out_href, out_vsync, frame_start, line_end, frame_done});
    end
    checks++;
    if ({pix_phase, pix_x, pix_y} !== 25'd0) begin
      errors++; $display("FAIL reset_coords: phase %0d x %0d y %0d required 0", pix_phase, pix_x, pix_y);
    end
    checks++;
    if ({err_line_len, err_frame_len, busy} !== 3'b0) begin
      errors++; $display("FAIL reset_flags: got %b required 000", {err_line_len, err_frame_len, busy});
    end
    rst = 1'b0;
    cyc(0, 0);
  endtask

  task automatic test_gating();
    logic bad_href, bad_cnt, bad_err, bad_busy;
    bad_href = 0; bad_cnt = 0; bad_err = 0; bad_busy = 0;
    cfg_enable = 1'b0;
    n_le = 0; n_fs = 0;
    for (int i = 0; i < 10; i++) begin
      cyc((i % 3) != 2, (i == 4 || i == 5));
      if (out_href !== 1'b0) bad_href = 1;
      if (pix_x !== 12'd0 || pix_y !== 11'd0) bad_cnt = 1;
      if (err_line_len !== 1'b0 || err_frame_len !== 1'b0) bad_err = 1;
      if (busy !== 1'b0) bad_busy = 1;
    end
    cyc(0, 0);
    checks++; if (bad_href) begin errors++; $display("FAIL gate_href: out_href rose, required 0"); end
    checks++; if (bad_cnt)  begin errors++; $display("FAIL gate_counters: nonzero coords, required 0"); end
    checks++; if (bad_err)  begin errors++; $display("FAIL gate_errors: error flag set, required 0"); end
    checks++; if (bad_busy) begin errors++; $display("FAIL gate_busy: busy set, required 0"); end
    checks++;
    if (n_le + n_fs !== 0) begin errors++; $display("FAIL gate_events: got %0d events, required 0", n_le + n_fs); end
  endtask

  task automatic test_nominal();
    cfg_enable = 1'b1; cfg_pattern = 2'b00;
    run_frame(4, -1, -1, 2'b00, -1, -1);
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL nom_frame_done: got %b required 1", frame_done); end
    checks++; if (out_vsync !== 1'b1) begin errors++; $display("FAIL nom_out_vsync: got %b required 1", out_vsync); end
    checks++; if (n_fs !== 1) begin errors++; $display("FAIL nom_fs_count: got %0d required 1", n_fs); end
    checks++; if (n_le !== 4) begin errors++; $display("FAIL nom_le_count: got %0d required 4", n_le); end
    checks++; if (n_fd !== 1) begin errors++; $display("FAIL nom_fd_count: got %0d required 1", n_fd); end
    checks++;
    if ({le_log[0], le_log[1], le_log[2], le_log[3]} !== 4'b1111) begin
      errors++; $display("FAIL nom_line_end_timing: got %b required 1111", {le_log[0], le_log[1], le_log[2], le_log[3]});
    end
    checks++;
    if ({ph_log[0][0], ph_log[0][1], ph_log[0][2], ph_log[0][3]} !== 8'b00_01_00_01) begin
      errors++; $display("FAIL nom_phase_line0: got %b required 00010001", {ph_log[0][0], ph_log[0][1], ph_log[0][2], ph_log[0][3]});
    end
    checks++;
    if ({ph_log[1][0], ph_log[1][1], ph_log[1][6], ph_log[1][7]} !== 8'b10_11_10_11) begin
      errors++; $display("FAIL nom_phase_line1: got %b required 10111011", {ph_log[1][0], ph_log[1][1], ph_log[1][6], ph_log[1][7]});
    end
    checks++;
    if (x_log[2][5] !== 12'd5 || x_log[3][7] !== 12'd7) begin
      errors++; $display("FAIL nom_pix_x: got %0d,%0d required 5,7", x_log[2][5], x_log[3][7]);
    end
    checks++;
    if (y_log[0] !== 11'd0 || y_log[3] !== 11'd3) begin
      errors++; $display("FAIL nom_pix_y: got %0d,%0d required 0,3", y_log[0], y_log[3]);
    end
    checks++;
    if (err_line_len !== 1'b0 || err_frame_len !== 1'b0) begin
      errors++; $display("FAIL nom_errors: got %b%b required 00", err_line_len, err_frame_len);
    end
  endtask

  task automatic test_pattern_change();
    cfg_pattern = 2'b00;
    run_frame(4, -1, 2, 2'b11, -1, -1);
    checks++;
    if ({ph_log[2][0], ph_log[3][0], ph_log[3][1]} !== 6'b00_10_11) begin
      errors++; $display("FAIL pat_mid_frame: got %b required 001011", {ph_log[2][0], ph_log[3][0], ph_log[3][1]});
    end
    run_frame(4, -1, -1, 2'b00, -1, -1);
    checks++;
    if ({ph_log[0][0], ph_log[0][1], ph_log[1][0], ph_log[1][1]} !== 8'b11_10_01_00) begin
      errors++; $display("FAIL pat_next_frame: got %b required 11100100", {ph_log[0][0], ph_log[0][1], ph_log[1][0], ph_log[1][1]});
    end
    cfg_pattern = 2'b00;
  endtask

  task automatic test_short_line();
    run_frame(4, 1, -1, 2'b00, -1, -1);
    checks++;
    if ({ele_log[0], ele_log[1], le_log[1]} !== 3'b011) begin
      errors++; $display("FAIL short_err_set: got %b required 011", {ele_log[0], ele_log[1], le_log[1]});
    end
    checks++; if (err_frame_len !== 1'b0) begin errors++; $display("FAIL short_frame_err: got %b required 0", err_frame_len); end
    run_frame(4, -1, -1, 2'b00, -1, -1);
    checks++; if (err_line_len !== 1'b1) begin errors++; $display("FAIL short_sticky: got %b required 1", err_line_len); end
    err_clr = 1'b1; cyc(0, 1); err_clr = 1'b0;
    checks++; if (err_line_len !== 1'b0) begin errors++; $display("FAIL short_clear: got %b required 0", err_line_len); end
    run_frame(4, 0, -1, 2'b00, 0, -1);
    checks++; if (ele_log[0] !== 1'b1) begin errors++; $display("FAIL short_set_beats_clr: got %b required 1", ele_log[0]); end
    checks++; if (err_line_len !== 1'b1) begin errors++; $display("FAIL short_set_held: got %b required 1", err_line_len); end
    err_clr = 1'b1; cyc(0, 1); err_clr = 1'b0;
  endtask

  task automatic test_frame_len();
    run_frame(5, -1, -1, 2'b00, -1, -1);
    checks++;
    if ({frame_done, err_frame_len, err_line_len} !== 3'b110) begin
      errors++; $display("FAIL flen_5_lines: got %b required 110", {frame_done, err_frame_len, err_line_len});
    end
    err_clr = 1'b1; cyc(0, 1); err_clr = 1'b0;
    checks++; if (err_frame_len !== 1'b0) begin errors++; $display("FAIL flen_clear: got %b required 0", err_frame_len); end
    run_frame(3, -1, -1, 2'b00, -1, -1);
    checks++;
    if ({frame_done, err_frame_len} !== 2'b11) begin
      errors++; $display("FAIL flen_3_lines: got %b required 11", {frame_done, err_frame_len});
    end
    err_clr = 1'b1; cyc(0, 1); err_clr = 1'b0;
    run_frame(4, -1, -1, 2'b00, -1, -1);
    checks++; if (err_frame_len !== 1'b0) begin errors++; $display("FAIL flen_4_lines: got %b required 0", err_frame_len); end
  endtask

  task automatic test_enable_drop();
    run_frame(4, -1, -1, 2'b00, -1, 2);
    checks++; if (n_le !== 4) begin errors++; $display("FAIL drop_lines: got %0d required 4", n_le); end
    checks++;
    if ({frame_done, busy, err_frame_len} !== 3'b100) begin
      errors++; $display("FAIL drop_end_state: fd/busy/err got %b required 100", {frame_done, busy, err_frame_len});
    end
    cyc(0, 1); cyc(0, 0); cyc(1, 0);
    checks++;
    if ({busy, out_href} !== 2'b00) begin errors++; $display("FAIL drop_idle: busy/href got %b required 00", {busy, out_href}); end
    cyc(0, 0);
  endtask

  task automatic test_reset_mid();
    logic bad_href;
    bad_href = 0;
    cfg_enable = 1'b1; cfg_pattern = 2'b00;
    cyc(0, 1); cyc(0, 1); cyc(0, 0);
    for (int p = 0; p < 4; p++) cyc(1, 0);
    checks++;
    if (pix_x !== 12'd3 || busy !== 1'b1) begin errors++; $display("FAIL rmid_pre: x %0d busy %b required 3 1", pix_x, busy); end
    rst = 1'b1; cyc(1, 0); rst = 1'b0;
    checks++;
    if ({out_href, pix_x, busy, pix_phase} !== 16'd0) begin
      errors++; $display("FAIL rmid_outputs: href %b x %0d busy %b phase %0d required 0", out_href, pix_x, busy, pix_phase);
    end
    for (int p = 0; p < 3; p++) begin
      cyc(1, 0);
      if (out_href !== 1'b0 || pix_x !== 12'd0) bad_href = 1;
    end
    cyc(0, 0);
    checks++; if (bad_href) begin errors++; $display("FAIL rmid_ignore_href: output moved, required 0"); end
    run_frame(4, -1, -1, 2'b00, -1, -1);
    checks++;
    if (n_fs !== 1 || n_le !== 4 || frame_done !== 1'b1) begin
      errors++; $display("FAIL rmid_frame_events: fs %0d le %0d fd %b required 1 4 1", n_fs, n_le, frame_done);
    end
    checks++;
    if ({err_line_len, err_frame_len, ph_log[1][1]} !== 4'b0011) begin
      errors++; $display("FAIL rmid_frame_clean: got %b required 0011", {err_line_len, err_frame_len, ph_log[1][1]});
    end
  endtask

  initial begin
    rst = 1'b1; cfg_enable = 1'b0; cfg_pattern = 2'b00; err_clr = 1'b0;
    in_href = 1'b0; in_vsync = 1'b0;
    n_fs = 0; n_le = 0; n_fd = 0;
    test_reset();
    test_gating();
    test_nominal();
    test_pattern_change();
    test_short_line();
    test_frame_len();
    test_enable_drop();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bayer_frame_ctrl.md
# bayer_frame_ctrl

Frame/line sequencer that sits in front of the Bayer-to-RGB888 converter in the HDMI capture path. It tracks the camera `in_vsync`/`in_href` timing and gates the sync signals passed downstream. It also generates the per-pixel Bayer colour phase from a configurable CFA pattern, so the converter no longer derives parity on its own. It provides pixel/line coordinates, frame/line event pulses and sticky geometry-error flags for the ISP control logic.

## Interface
Parameters:
- `H_ACT`, 1280: expected active pixels per line.
- `V_ACT`, 720: expected active lines per frame.
- `XW`, 12: width of the pixel counter.
- `YW`, 11: width of the line counter.

Ports:
- `pclk`, in, 1: pixel clock; the only clock.
- `rst`, in, 1: synchronous, active-high reset.
- `cfg_enable`, in, 1: start/continue capturing frames.
- `cfg_pattern`, in, 2: CFA pattern at (0,0). 00 RGGB, 01 GRBG, 10 GBRG, 11 BGGR.
- `err_clr`, in, 1: clears the sticky error flags.
- `in_href`, in, 1: camera line-valid.
- `in_vsync`, in, 1: camera frame sync, active high.
- `out_href`, out, 1: gated line-valid, delayed 1 cycle.
- `out_vsync`, out, 1: `in_vsync` delayed 1 cycle.
- `pix_phase`, out, 2: colour of the current pixel. 00 R, 01 G on R row, 10 G on B row, 11 B.
- `pix_x`, out, XW: column index of the current pixel.
- `pix_y`, out, YW: row index of the current line.
- `frame_start`, out, 1: 1-cycle pulse on the first `out_href` cycle of a frame.
- `line_end`, out, 1: 1-cycle pulse after the last pixel of a line.
- `frame_done`, out, 1: 1-cycle pulse at the end of a frame.
- `err_line_len`, out, 1: sticky; some line length was not equal to `H_ACT`.
- `err_frame_len`, out, 1: sticky; some frame line count was not equal to `V_ACT`.
- `busy`, out, 1: state is not WAIT_VS.

## Operation
- The FSM has three states: WAIT_VS, IN_VS, ACTIVE. Reset enters WAIT_VS.
- **WAIT_VS → IN_VS:** when `cfg_enable` and `in_vsync` are both high.
- **IN_VS → ACTIVE:** on the `in_vsync` falling edge (registered previous value = 1, current value = 0).
  - `cfg_pattern` is latched into a shadow register here; mid-frame changes are ignored.
  - The line counter is cleared.
- **ACTIVE, each cycle with `in_href`=1:**
  - The x counter increments. It saturates at 2^XW−1 and never wraps.
- **ACTIVE, on `in_href` falling edge:**
  - Fire `line_end`.
  - If the x count is not equal to `H_ACT`, set `err_line_len`.
  - Clear x; increment y, saturating at 2^YW−1.
- **ACTIVE, on `in_vsync` rising edge:**
  - Fire `frame_done`.
  - If the completed line count is not equal to `V_ACT`, set `err_frame_len`.
  - Go to IN_VS if `cfg_enable` is high, else WAIT_VS. This allows back-to-back frames.
  - If `in_href` falls in the same cycle, `line_end` is processed first and the completed line count includes that line.
- **`cfg_enable` deasserted mid-frame:** the current frame completes normally. Only the next vsync is affected.
- **Gating:** `out_href` = `in_href` registered AND (state == ACTIVE). `in_href` in WAIT_VS or IN_VS is ignored: no counting and no errors.
- **Phase:** `pix_phase` = shadow_pattern XOR {y[0], x[0]}, using the pixel's own coordinates.
- **Error flags:**
  - Set by events. Cleared by `err_clr`.
  - If a set event and `err_clr` occur in the same cycle, the set wins.
- **Reset mid-operation:** all state and outputs return to reset values on the next edge. Capture resumes only at the next vsync.

## Timing
- **Reset values:**
  - All outputs are 0.
  - The shadow pattern is 00 (RGGB).
  - The state is WAIT_VS.
- **Latency:** all outputs are registered, 1 pclk after the sampled inputs. The downstream converter must delay `bayer_data` 1 cycle to align with `out_href`, `pix_phase` and `pix_x`.
- **Coordinates:** while `out_href`=1, `pix_x` runs 0,1,2,… and `pix_y` is constant for the line.
- **`frame_start`:** asserted when `out_href`=1, `pix_x`=0, `pix_y`=0.
- **`line_end`:** asserted in the first cycle where `out_href`=0 after a high run.
- **`frame_done`:** asserted in the cycle `out_vsync` first rises after ACTIVE.
- **Event separation:** `frame_done` and `line_end` fire in the same cycle only when `in_href` falls and `in_vsync` rises in the same cycle.

## Test plan
Bench parameters: `H_ACT`=8, `V_ACT`=4.

- **Nominal frame:** `cfg_pattern`=00, `cfg_enable`=1, one vsync, then 4 lines of 8 href cycles.
  - Line 0 `pix_phase` = 00,01,00,01,… ; line 1 = 10,11,…
  - `frame_start` appears once, `line_end` ×4, `frame_done` ×1.
  - No errors.
- **Pattern change mid-frame:** `cfg_pattern` 00→11 during line 2.
  - The rest of the frame keeps RGGB phases.
  - The next frame's first pixel has `pix_phase`=11.
- **Short line:** line 1 has only 7 pixels.
  - `err_line_len`=1 after that `line_end`; it stays 1 across frames until `err_clr`.
  - Simultaneous set event and `err_clr`: the flag stays 1.
- **Frame line count:** a frame with 5 lines sets `err_frame_len` at `frame_done`. A frame with 3 lines also sets it.
- **Gating:** href pulses before the first vsync with `cfg_enable`=0.
  - `out_href` stays 0, counters stay 0, no errors.
  - `cfg_enable` dropped mid-frame: the frame finishes, then the FSM returns to WAIT_VS and `busy`=0.
- **Reset mid-line:** `rst` asserted at `pix_x`=3.
  - All outputs are 0 on the next edge.
  - href before the next vsync is ignored; the frame after vsync is nominal.
